// File: rtl/uart_io_txbuf.sv
// CPU-side character output buffer: memory-mapped FIFO drained one character per handshake
// toward the UART monitor. Define UART_IO_CRLF_EN to expand each LF into a CR, LF pair.
module uart_io_txbuf #(
    parameter int unsigned DEPTH_LOG = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_wen,
    input  logic [3:2]  io_wadr,
    input  logic [31:0] io_wdata,
    input  logic        io_ren,
    input  logic [3:2]  io_radr,
    output logic [31:0] io_rdata,
    output logic [7:0]  uart_io_char,
    output logic        uart_io_we,
    input  logic        uart_io_full,
    output logic        irq_txempty
);

    localparam int unsigned Depth = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] FullCount = {1'b1, {DEPTH_LOG{1'b0}}};

`ifdef UART_IO_CRLF_EN
    typedef enum logic [2:0] {StIdle, StSend, StGap, StCrSend, StCrGap} state_e;
`else
    typedef enum logic [2:0] {StIdle, StSend, StGap} state_e;
`endif

    state_e               state_q;
    logic [7:0]           mem_q [Depth];
    logic [DEPTH_LOG-1:0] wr_ptr_q;
    logic [DEPTH_LOG-1:0] rd_ptr_q;
    logic [DEPTH_LOG:0]   count_q;
    logic                 ovf_q;
    logic                 enable_q;
    logic                 ie_q;

    logic        full;
    logic        empty;
    logic        push_req;
    logic        push_ok;
    logic        pop;
    logic        start;
    logic        ctrl_wr;
    logic [7:0]  head;
    logic [31:0] status;
    logic [31:0] rd_mux;

    always_comb begin
        full     = (count_q == FullCount);
        empty    = (count_q == '0);
        head     = mem_q[rd_ptr_q];
        push_req = io_wen && (io_wadr == 2'd0);
        ctrl_wr  = io_wen && (io_wadr == 2'd2);
        start    = (state_q == StIdle) && enable_q && !empty && !uart_io_full;
`ifdef UART_IO_CRLF_EN
        // An LF stays queued until its own send is issued after the CR.
        pop = (start && (head != 8'h0A)) || ((state_q == StCrGap) && !uart_io_full);
`else
        pop = start;
`endif
        // A same-cycle pop frees the slot first, so a store to a full FIFO still lands.
        push_ok = push_req && (!full || pop);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= io_wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            enable_q <= 1'b1;
            ie_q     <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A dropped store outranks a simultaneous clear.
            if (push_req && !push_ok) begin
                ovf_q <= 1'b1;
            end else if (ctrl_wr && io_wdata[2]) begin
                ovf_q <= 1'b0;
            end
            if (ctrl_wr) begin
                enable_q <= io_wdata[0];
                ie_q     <= io_wdata[1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            uart_io_char <= 8'h00;
            uart_io_we   <= 1'b0;
        end else begin
            uart_io_we <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
`ifdef UART_IO_CRLF_EN
                        if (head == 8'h0A) begin
                            uart_io_char <= 8'h0D;
                            uart_io_we   <= 1'b1;
                            state_q      <= StCrSend;
                        end else begin
                            uart_io_char <= head;
                            uart_io_we   <= 1'b1;
                            state_q      <= StSend;
                        end
`else
                        uart_io_char <= head;
                        uart_io_we   <= 1'b1;
                        state_q      <= StSend;
`endif
                    end
                end
                StSend: state_q <= StGap;
                StGap:  state_q <= StIdle;
`ifdef UART_IO_CRLF_EN
                StCrSend: state_q <= StCrGap;
                StCrGap: begin
                    if (!uart_io_full) begin
                        uart_io_char <= 8'h0A;
                        uart_io_we   <= 1'b1;
                        state_q      <= StSend;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        status                  = '0;
        status[0]               = full;
        status[1]               = empty;
        status[2]               = ovf_q;
        status[8+DEPTH_LOG:8]   = count_q;
        case (io_radr)
            2'd1:    rd_mux = status;
            2'd2:    rd_mux = {30'd0, ie_q, enable_q};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_rdata <= '0;
        end else begin
            io_rdata <= io_ren ? rd_mux : 32'd0;
        end
    end

    assign irq_txempty = empty && enable_q && ie_q;

endmodule

// File: tb/tb_uart_io_txbuf.sv
// Directed bench for uart_io_txbuf: register table plus hand-written drain sequences.
module tb_uart_io_txbuf;

    logic        clk;
    logic        rst_n;
    logic        io_wen;
    logic [3:2]  io_wadr;
    logic [31:0] io_wdata;
    logic        io_ren;
    logic [3:2]  io_radr;
    logic [31:0] io_rdata;
    logic [7:0]  uart_io_char;
    logic        uart_io_we;
    logic        uart_io_full;
    logic        irq_txempty;

    uart_io_txbuf #(.DEPTH_LOG(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .io_wen       (io_wen),
        .io_wadr      (io_wadr),
        .io_wdata     (io_wdata),
        .io_ren       (io_ren),
        .io_radr      (io_radr),
        .io_rdata     (io_rdata),
        .uart_io_char (uart_io_char),
        .uart_io_we   (uart_io_we),
        .uart_io_full (uart_io_full),
        .irq_txempty  (irq_txempty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] got_q [$];
    int         got_cyc_q [$];
    logic [7:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && uart_io_we) begin
            got_q.push_back(uart_io_char);
            got_cyc_q.push_back(cyc);
        end
    end

    typedef struct {
        logic        wen;
        logic [1:0]  wadr;
        logic [31:0] wdata;
        logic        ren;
        logic [1:0]  radr;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [10];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        io_wen   = 1'b1;
        io_wadr  = a;
        io_wdata = d;
        @(negedge clk);
        io_wen   = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        io_ren  = 1'b1;
        io_radr = a;
        @(negedge clk);
        io_ren  = 1'b0;
        check32(name, io_rdata, exp);
    endtask

    task automatic check_stream(input string name);
        check32({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check32($sformatf("%s_char%0d", name, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        end
        got_q.delete();
        got_cyc_q.delete();
        exp_q.delete();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        got_q.delete();
        got_cyc_q.delete();
    endtask

    initial begin
        // wen wadr wdata ren radr exp_rdata exp_irq; full held high so nothing drains
        vecs[0] = '{1'b0, 2'd0, 32'h0,        1'b1, 2'd1, 32'h0000_0002, 1'b0};
        vecs[1] = '{1'b0, 2'd0, 32'h0,        1'b1, 2'd2, 32'h0000_0001, 1'b0};
        vecs[2] = '{1'b0, 2'd0, 32'h0,        1'b1, 2'd3, 32'h0000_0000, 1'b0};
        vecs[3] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 1'b0, 2'd1, 32'h0000_0000, 1'b0};
        vecs[4] = '{1'b1, 2'd2, 32'h3,        1'b1, 2'd1, 32'h0000_0002, 1'b1};
        vecs[5] = '{1'b0, 2'd0, 32'h0,        1'b1, 2'd2, 32'h0000_0003, 1'b1};
        vecs[6] = '{1'b1, 2'd0, 32'h41,       1'b1, 2'd1, 32'h0000_0002, 1'b0};
        vecs[7] = '{1'b0, 2'd0, 32'h0,        1'b1, 2'd1, 32'h0000_0100, 1'b0};
        vecs[8] = '{1'b1, 2'd2, 32'h1,        1'b1, 2'd2, 32'h0000_0003, 1'b0};
        vecs[9] = '{1'b0, 2'd0, 32'h0,        1'b1, 2'd2, 32'h0000_0001, 1'b0};

        rst_n        = 1'b0;
        io_wen       = 1'b0;
        io_wadr      = 2'd0;
        io_wdata     = '0;
        io_ren       = 1'b0;
        io_radr      = 2'd0;
        uart_io_full = 1'b0;
        repeat (2) @(negedge clk);
        check32("reset_we", {31'd0, uart_io_we}, 32'd0);
        check32("reset_char", {24'd0, uart_io_char}, 32'd0);
        check32("reset_rdata", io_rdata, 32'd0);
        check32("reset_irq", {31'd0, irq_txempty}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        rd_check("reset_status", 2'd1, 32'h0000_0002);
        repeat (20) @(negedge clk);
        check32("idle_no_we", 32'(got_q.size()), 32'd0);

        uart_io_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            io_wen   = vecs[i].wen;
            io_wadr  = vecs[i].wadr;
            io_wdata = vecs[i].wdata;
            io_ren   = vecs[i].ren;
            io_radr  = vecs[i].radr;
            @(negedge clk);
            io_wen = 1'b0;
            io_ren = 1'b0;
            check32($sformatf("vec%0d_rdata", i), io_rdata, vecs[i].exp_rdata);
            check32($sformatf("vec%0d_irq", i), {31'd0, irq_txempty}, {31'd0, vecs[i].exp_irq});
        end
        pulse_reset();
        uart_io_full = 1'b0;

        // Three back-to-back stores drain one every 3 cycles.
        wr(2'd0, 32'h41);
        wr(2'd0, 32'h42);
        wr(2'd0, 32'h43);
        repeat (15) @(negedge clk);
        check32("abc_gap01", 32'(got_cyc_q.size() > 1 ? got_cyc_q[1] - got_cyc_q[0] : 0), 32'd3);
        check32("abc_gap12", 32'(got_cyc_q.size() > 2 ? got_cyc_q[2] - got_cyc_q[1] : 0), 32'd3);
        exp_q = '{8'h41, 8'h42, 8'h43};
        check_stream("abc");
        rd_check("abc_status", 2'd1, 32'h0000_0002);

        // Overflow: 17 stores into a stalled FIFO, the last is dropped.
        uart_io_full = 1'b1;
        for (int i = 0; i < 17; i++) wr(2'd0, 32'h50 + 32'(i));
        rd_check("ovf_status", 2'd1, 32'h0000_1005);
        uart_io_full = 1'b0;
        repeat (60) @(negedge clk);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h50 + i));
        check_stream("ovf_drain");
        wr(2'd2, 32'h5);
        rd_check("ovf_clr_status", 2'd1, 32'h0000_0002);
        rd_check("ovf_clr_ctrl", 2'd2, 32'h0000_0001);

        // Store lands in the same cycle as a pop from a full FIFO.
        uart_io_full = 1'b1;
        for (int i = 0; i < 16; i++) wr(2'd0, 32'h60 + 32'(i));
        rd_check("full_status", 2'd1, 32'h0000_1001);
        uart_io_full = 1'b0;
        wr(2'd0, 32'h70);
        rd_check("pushpop_status", 2'd1, 32'h0000_1001);
        repeat (60) @(negedge clk);
        for (int i = 0; i < 17; i++) exp_q.push_back(8'(8'h60 + i));
        check_stream("pushpop_drain");

        // Disabled drain holds characters until ENABLE returns.
        wr(2'd2, 32'h0);
        wr(2'd0, 32'h31);
        wr(2'd0, 32'h32);
        repeat (20) @(negedge clk);
        check32("disabled_no_we", 32'(got_q.size()), 32'd0);
        check32("disabled_irq", {31'd0, irq_txempty}, 32'd0);
        wr(2'd2, 32'h3);
        repeat (20) @(negedge clk);
        exp_q = '{8'h31, 8'h32};
        check_stream("enabled");
        check32("txempty_irq", {31'd0, irq_txempty}, 32'd1);
        wr(2'd2, 32'h1);

        wr(2'd0, 32'h0A);
        repeat (15) @(negedge clk);
`ifdef UART_IO_CRLF_EN
        exp_q = '{8'h0D, 8'h0A};
`else
        exp_q = '{8'h0A};
`endif
        check_stream("lf");

        // Reset in the middle of a drain.
        wr(2'd0, 32'h0B);
        wr(2'd0, 32'h0C);
        wr(2'd0, 32'h0D);
        for (int i = 0; i < 10 && !uart_io_we; i++) @(negedge clk);
        check32("mid_we_seen", {31'd0, uart_io_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check32("mid_rst_we", {31'd0, uart_io_we}, 32'd0);
        check32("mid_rst_char", {24'd0, uart_io_char}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        got_q.delete();
        got_cyc_q.delete();
        rd_check("mid_rst_status", 2'd1, 32'h0000_0002);
        rd_check("mid_rst_ctrl", 2'd2, 32'h0000_0001);
        repeat (20) @(negedge clk);
        check32("mid_rst_no_we", 32'(got_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
